fight_turn_control: RTL and testbench

FIGHT_TURN_CONTROL -- requirements
Module: fight_turn_control

---
 rtl/fight_turn_control_pkg.sv | 40 ++++
 rtl/fight_turn_control_anim_timer.sv | 47 ++++
 rtl/fight_turn_control.sv | 231 +++++++++++++++++++++++
 tb/tb_fight_turn_control.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fight_turn_control_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fight_turn_control_pkg                                     |
// | Description : Shared definitions for the turn-based fight controller:    |
// |               scene codes, fight FSM state encoding, one-hot key codes   |
// |               and a saturating HP subtraction helper.                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package fight_turn_control_pkg;

    // Scene codes driven by the game's scene controller
    localparam logic [3:0] c_scene_start  = 4'b0001;
    localparam logic [3:0] c_scene_choose = 4'b0010;
    localparam logic [3:0] c_scene_fight  = 4'b0011;
    localparam logic [3:0] c_scene_win    = 4'b0100;

    // Fight FSM encoding (visible on the fight_state output)
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_ANIMATE = 3'd2,
        ST_APPLY   = 3'd3,
        ST_CHECK   = 3'd4,
        ST_DONE    = 3'd5
    } fight_state_t;

    // Key vector ordering is {U, D, L, R, C}; a valid press is exactly one bit
    localparam logic [4:0] c_key_u = 5'b10000;
    localparam logic [4:0] c_key_d = 5'b01000;
    localparam logic [4:0] c_key_l = 5'b00100;
    localparam logic [4:0] c_key_r = 5'b00010;
    localparam logic [4:0] c_key_c = 5'b00001;

    // HP never wraps: damage larger than remaining HP leaves 0
    function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : 8'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fight_turn_control_anim_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fight_anim_timer                                           |
// | Description : Attack-animation hold timer. A start pulse arms it; done   |
// |               pulses in the last of ANIM_CYCLES clocks so the FSM leaves |
// |               ANIMATE after exactly ANIM_CYCLES clocks. abort clears it. |
// | Ports       : clk, reset (async, active-high), start, abort -> done      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fight_anim_timer #(
    parameter int ANIM_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic abort,
    output logic done
);

    localparam logic [7:0] c_load = 8'(ANIM_CYCLES - 1);

    logic [7:0] r_count;
    logic       r_active;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count  <= 8'd0;
            r_active <= 1'b0;
        end else if (abort) begin
            r_count  <= 8'd0;
            r_active <= 1'b0;
        end else if (start) begin
            r_count  <= c_load;
            r_active <= 1'b1;
        end else if (r_active) begin
            if (r_count == 8'd0) begin
                r_active <= 1'b0;
            end else begin
                r_count <= r_count - 8'd1;
            end
        end
    end

    assign done = r_active && (r_count == 8'd0);

endmodule
`default_nettype wire

// File: rtl/fight_turn_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fight_turn_control                                         |
// | Description : Turn-based fight controller. Loads both fighters' stats on |
// |               entering the fight scene, lets the attacker pick a skill,  |
// |               holds an attack animation, applies saturating damage and   |
// |               alternates turns until one side reaches 0 HP.              |
// | Ports       : clk, reset (async, active-high), scene_state[3:0],         |
// |               key_U/D/L/R/C pulses, p1_*/p2_* stats (8b) ->              |
// |               p1_cur_hp, p2_cur_hp, turn, skill_cursor, fight_state,     |
// |               anim_busy, fight_done, winner                              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fight_turn_control
    import fight_turn_control_pkg::*;
#(
    parameter logic [3:0] FIGHT_SCENE = 4'b0011,
    parameter int         ANIM_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] scene_state,
    input  logic       key_U,
    input  logic       key_D,
    input  logic       key_L,
    input  logic       key_R,
    input  logic       key_C,
    input  logic [7:0] p1_pokemon_hp,
    input  logic [7:0] p1_pokemon_speed,
    input  logic [7:0] p1_skill_1_damage,
    input  logic [7:0] p1_skill_2_damage,
    input  logic [7:0] p1_skill_3_damage,
    input  logic [7:0] p2_pokemon_hp,
    input  logic [7:0] p2_pokemon_speed,
    input  logic [7:0] p2_skill_1_damage,
    input  logic [7:0] p2_skill_2_damage,
    input  logic [7:0] p2_skill_3_damage,
    output logic [7:0] p1_cur_hp,
    output logic [7:0] p2_cur_hp,
    output logic       turn,
    output logic [1:0] skill_cursor,
    output logic [2:0] fight_state,
    output logic       anim_busy,
    output logic       fight_done,
    output logic       winner
);

    fight_state_t r_state;
    fight_state_t w_state_next;

    logic [7:0] r_p1_hp;
    logic [7:0] r_p2_hp;
    logic       r_turn;
    logic [1:0] r_cursor;
    logic [7:0] r_damage;
    logic       r_winner;
    logic       r_fight_done;

    // Skill damages are captured at fight entry so later stat changes on the
    // inputs cannot alter a fight in progress.
    logic [7:0] r_p1_skill_1, r_p1_skill_2, r_p1_skill_3;
    logic [7:0] r_p2_skill_1, r_p2_skill_2, r_p2_skill_3;

    logic [4:0] w_keys;
    logic       w_in_scene;
    logic       w_key_l;
    logic       w_key_r;
    logic       w_key_c;
    logic [7:0] w_defender_hp;
    logic [7:0] w_sel_damage;
    logic       w_anim_done;
    logic       w_load;
    logic       w_fire;
    logic       w_apply;
    logic       w_finish;
    logic       w_next_turn;

    // Comparing the whole vector against a one-hot code rejects multi-key cycles
    assign w_keys        = {key_U, key_D, key_L, key_R, key_C};
    assign w_key_l       = (w_keys == c_key_l);
    assign w_key_r       = (w_keys == c_key_r);
    assign w_key_c       = (w_keys == c_key_c);
    assign w_in_scene    = (scene_state == FIGHT_SCENE);
    assign w_defender_hp = r_turn ? r_p1_hp : r_p2_hp;

    always_comb begin
        w_sel_damage = 8'd0;
        case (r_cursor)
            2'd0:    w_sel_damage = r_turn ? r_p2_skill_1 : r_p1_skill_1;
            2'd1:    w_sel_damage = r_turn ? r_p2_skill_2 : r_p1_skill_2;
            default: w_sel_damage = r_turn ? r_p2_skill_3 : r_p1_skill_3;
        endcase
    end

    fight_anim_timer #(
        .ANIM_CYCLES (ANIM_CYCLES)
    ) u_anim_timer (
        .clk   (clk),
        .reset (reset),
        .start (w_fire),
        .abort (!w_in_scene),
        .done  (w_anim_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_fire       = 1'b0;
        w_apply      = 1'b0;
        w_finish     = 1'b0;
        w_next_turn  = 1'b0;
        if (!w_in_scene) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_next = ST_SELECT;
                    w_load       = 1'b1;
                end
                ST_SELECT: begin
                    if (w_key_c) begin
                        w_state_next = ST_ANIMATE;
                        w_fire       = 1'b1;
                    end
                end
                ST_ANIMATE: begin
                    if (w_anim_done) begin
                        w_state_next = ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    w_state_next = ST_CHECK;
                    w_apply      = 1'b1;
                end
                ST_CHECK: begin
                    if (w_defender_hp == 8'd0) begin
                        w_state_next = ST_DONE;
                        w_finish     = 1'b1;
                    end else begin
                        w_state_next = ST_SELECT;
                        w_next_turn  = 1'b1;
                    end
                end
                ST_DONE: begin
                    w_state_next = ST_DONE;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p1_hp      <= 8'd0;
            r_p2_hp      <= 8'd0;
            r_turn       <= 1'b0;
            r_cursor     <= 2'd0;
            r_damage     <= 8'd0;
            r_winner     <= 1'b0;
            r_fight_done <= 1'b0;
            r_p1_skill_1 <= 8'd0;
            r_p1_skill_2 <= 8'd0;
            r_p1_skill_3 <= 8'd0;
            r_p2_skill_1 <= 8'd0;
            r_p2_skill_2 <= 8'd0;
            r_p2_skill_3 <= 8'd0;
        end else begin
            if (!w_in_scene) begin
                r_fight_done <= 1'b0;
            end
            if (w_load) begin
                r_p1_hp      <= p1_pokemon_hp;
                r_p2_hp      <= p2_pokemon_hp;
                r_turn       <= (p2_pokemon_speed > p1_pokemon_speed);
                r_cursor     <= 2'd0;
                r_p1_skill_1 <= p1_skill_1_damage;
                r_p1_skill_2 <= p1_skill_2_damage;
                r_p1_skill_3 <= p1_skill_3_damage;
                r_p2_skill_1 <= p2_skill_1_damage;
                r_p2_skill_2 <= p2_skill_2_damage;
                r_p2_skill_3 <= p2_skill_3_damage;
            end
            if (w_in_scene && (r_state == ST_SELECT)) begin
                if (w_key_l && (r_cursor != 2'd0)) begin
                    r_cursor <= r_cursor - 2'd1;
                end else if (w_key_r && (r_cursor != 2'd2)) begin
                    r_cursor <= r_cursor + 2'd1;
                end
            end
            if (w_fire) begin
                r_damage <= w_sel_damage;
            end
            if (w_apply) begin
                if (r_turn) begin
                    r_p1_hp <= sat_sub(r_p1_hp, r_damage);
                end else begin
                    r_p2_hp <= sat_sub(r_p2_hp, r_damage);
                end
            end
            if (w_finish) begin
                r_winner     <= r_turn;
                r_fight_done <= 1'b1;
            end
            if (w_next_turn) begin
                r_turn   <= ~r_turn;
                r_cursor <= 2'd0;
            end
        end
    end

    assign p1_cur_hp    = r_p1_hp;
    assign p2_cur_hp    = r_p2_hp;
    assign turn         = r_turn;
    assign skill_cursor = r_cursor;
    assign fight_state  = r_state;
    assign anim_busy    = (r_state == ST_ANIMATE);
    assign fight_done   = r_fight_done;
    assign winner       = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_fight_turn_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fight_turn_control                                      |
// | Description : Self-checking bench for fight_turn_control: directed       |
// |               scenarios plus randomized fights compared against a        |
// |               behavioural fight model.                                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_fight_turn_control;
    import fight_turn_control_pkg::*;

    localparam int         ANIM  = 6;
    localparam logic [3:0] FIGHT = 4'b0011;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] scene_state;
    logic       key_U, key_D, key_L, key_R, key_C;
    logic [7:0] p1_pokemon_hp, p1_pokemon_speed, p1_skill_1_damage, p1_skill_2_damage, p1_skill_3_damage;
    logic [7:0] p2_pokemon_hp, p2_pokemon_speed, p2_skill_1_damage, p2_skill_2_damage, p2_skill_3_damage;
    logic [7:0] p1_cur_hp, p2_cur_hp;
    logic       turn;
    logic [1:0] skill_cursor;
    logic [2:0] fight_state;
    logic       anim_busy, fight_done, winner;

    fight_turn_control #(
        .FIGHT_SCENE (FIGHT),
        .ANIM_CYCLES (ANIM)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .scene_state       (scene_state),
        .key_U             (key_U),
        .key_D             (key_D),
        .key_L             (key_L),
        .key_R             (key_R),
        .key_C             (key_C),
        .p1_pokemon_hp     (p1_pokemon_hp),
        .p1_pokemon_speed  (p1_pokemon_speed),
        .p1_skill_1_damage (p1_skill_1_damage),
        .p1_skill_2_damage (p1_skill_2_damage),
        .p1_skill_3_damage (p1_skill_3_damage),
        .p2_pokemon_hp     (p2_pokemon_hp),
        .p2_pokemon_speed  (p2_pokemon_speed),
        .p2_skill_1_damage (p2_skill_1_damage),
        .p2_skill_2_damage (p2_skill_2_damage),
        .p2_skill_3_damage (p2_skill_3_damage),
        .p1_cur_hp         (p1_cur_hp),
        .p2_cur_hp         (p2_cur_hp),
        .turn              (turn),
        .skill_cursor      (skill_cursor),
        .fight_state       (fight_state),
        .anim_busy         (anim_busy),
        .fight_done        (fight_done),
        .winner            (winner)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stats the bench intends to present at the next fight entry
    int s_hp1, s_spd1, s_hp2, s_spd2;
    int s_sk1 [3];
    int s_sk2 [3];

    // Behavioural fight model
    int m_hp1, m_hp2, m_turn, m_cursor, m_done, m_winner;
    int m_sk1 [3];
    int m_sk2 [3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".p1_hp"},  32'(p1_cur_hp),    32'(m_hp1));
        check({tag, ".p2_hp"},  32'(p2_cur_hp),    32'(m_hp2));
        check({tag, ".turn"},   32'(turn),         32'(m_turn));
        check({tag, ".cursor"}, 32'(skill_cursor), 32'(m_cursor));
        check({tag, ".done"},   32'(fight_done),   32'(m_done));
        check({tag, ".winner"}, 32'(winner),       32'(m_winner));
    endtask

    task automatic check_state(input string tag, input fight_state_t st);
        check({tag, ".state"}, 32'(fight_state), 32'(st));
        check({tag, ".busy"},  32'(anim_busy),   (st == ST_ANIMATE) ? 32'd1 : 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_keys(input logic [4:0] k);
        {key_U, key_D, key_L, key_R, key_C} = k;
    endtask

    task automatic set_stats(input int hp1, input int spd1, input int a1, input int b1, input int c1,
                             input int hp2, input int spd2, input int a2, input int b2, input int c2);
        s_hp1 = hp1; s_spd1 = spd1; s_sk1[0] = a1; s_sk1[1] = b1; s_sk1[2] = c1;
        s_hp2 = hp2; s_spd2 = spd2; s_sk2[0] = a2; s_sk2[1] = b2; s_sk2[2] = c2;
    endtask

    // Stat inputs are garbage outside fight entry; the DUT must ignore them
    task automatic scramble_stats();
        {p1_pokemon_hp, p1_pokemon_speed, p1_skill_1_damage, p1_skill_2_damage} = $urandom;
        {p2_pokemon_hp, p2_pokemon_speed, p2_skill_1_damage, p2_skill_2_damage} = $urandom;
        p1_skill_3_damage = 8'($urandom);
        p2_skill_3_damage = 8'($urandom);
    endtask

    task automatic enter_fight(input string tag);
        p1_pokemon_hp = 8'(s_hp1); p1_pokemon_speed = 8'(s_spd1);
        p1_skill_1_damage = 8'(s_sk1[0]); p1_skill_2_damage = 8'(s_sk1[1]); p1_skill_3_damage = 8'(s_sk1[2]);
        p2_pokemon_hp = 8'(s_hp2); p2_pokemon_speed = 8'(s_spd2);
        p2_skill_1_damage = 8'(s_sk2[0]); p2_skill_2_damage = 8'(s_sk2[1]); p2_skill_3_damage = 8'(s_sk2[2]);
        scene_state = FIGHT;
        tick();
        scramble_stats();
        m_hp1 = s_hp1; m_hp2 = s_hp2;
        m_turn = (s_spd2 > s_spd1) ? 1 : 0;
        m_cursor = 0; m_done = 0;
        for (int i = 0; i < 3; i++) begin
            m_sk1[i] = s_sk1[i];
            m_sk2[i] = s_sk2[i];
        end
        check_state(tag, ST_SELECT);
        check_all(tag);
    endtask

    task automatic leave_scene(input string tag, input logic [3:0] code);
        scene_state = code;
        tick();
        m_done = 0;
        check_state(tag, ST_IDLE);
        check_all(tag);
    endtask

    task automatic press(input string tag, input logic [4:0] k, input bit in_sel);
        drive_keys(k);
        tick();
        drive_keys(5'b0);
        if (in_sel) begin
            if (k == 5'b00100 && m_cursor > 0) m_cursor--;
            else if (k == 5'b00010 && m_cursor < 2) m_cursor++;
        end
        check({tag, ".cursor"}, 32'(skill_cursor), 32'(m_cursor));
    endtask

    task automatic press_rand(input string tag);
        logic [4:0] k;
        k = 5'($urandom);
        if (k == 5'b00001) k = 5'b0;
        press(tag, k, 1'b1);
    endtask

    // Full attack: key_C, ANIM clocks of animation, APPLY, CHECK
    task automatic attack(input string tag);
        int att, dmg;
        att = m_turn;
        dmg = (att != 0) ? m_sk2[m_cursor] : m_sk1[m_cursor];
        drive_keys(5'b00001);
        tick();
        drive_keys(5'b0);
        check_state({tag, ".anim"}, ST_ANIMATE);
        for (int i = 1; i < ANIM; i++) begin
            drive_keys(5'($urandom));
            tick();
            drive_keys(5'b0);
            check_state({tag, ".anim"}, ST_ANIMATE);
            check_all({tag, ".anim"});
        end
        tick();
        check_state({tag, ".apply"}, ST_APPLY);
        check_all({tag, ".pre_hp"});
        tick();
        if (att == 0) m_hp2 = (m_hp2 > dmg) ? m_hp2 - dmg : 0;
        else          m_hp1 = (m_hp1 > dmg) ? m_hp1 - dmg : 0;
        check_state({tag, ".check"}, ST_CHECK);
        check_all({tag, ".hp"});
        tick();
        if (((att == 0) ? m_hp2 : m_hp1) == 0) begin
            m_done = 1;
            m_winner = att;
            check_state({tag, ".end"}, ST_DONE);
        end else begin
            m_turn = 1 - m_turn;
            m_cursor = 0;
            check_state({tag, ".next"}, ST_SELECT);
        end
        check_all({tag, ".after"});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        scene_state = c_scene_start;
        drive_keys(5'b0);
        set_stats(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        scramble_stats();
        m_hp1 = 0; m_hp2 = 0; m_turn = 0; m_cursor = 0; m_done = 0; m_winner = 0;
        tick();
        tick();
        check_state("reset", ST_IDLE);
        check_all("reset");
        reset = 1'b0;
        tick();
        check_state("idle", ST_IDLE);

        // First-attacker selection by speed
        set_stats(100, 200, 1, 2, 3, 80, 150, 4, 5, 6);
        enter_fight("spd_200_150");
        leave_scene("leave1", c_scene_choose);
        set_stats(100, 100, 1, 2, 3, 80, 100, 4, 5, 6);
        enter_fight("spd_tie");
        leave_scene("leave2", c_scene_choose);
        set_stats(100, 50, 1, 2, 3, 80, 99, 4, 5, 6);
        enter_fight("spd_p2_faster");
        leave_scene("leave3", c_scene_choose);
        for (int i = 0; i < 4; i++) begin
            set_stats(100, $urandom_range(0, 255), 1, 2, 3, 80, $urandom_range(0, 255), 4, 5, 6);
            enter_fight("spd_rand");
            leave_scene("leave_rand", c_scene_choose);
        end

        // Cursor movement, saturation and multi-key rejection
        set_stats(100, 200, 10, 40, 50, 60, 150, 10, 20, 30);
        enter_fight("cursor_entry");
        press("cur_L1", 5'b00100, 1'b1);
        press("cur_L2", 5'b00100, 1'b1);
        press("cur_R1", 5'b00010, 1'b1);
        press("cur_R2", 5'b00010, 1'b1);
        press("cur_R3", 5'b00010, 1'b1);
        press("cur_LR", 5'b00110, 1'b1);
        press("cur_U",  5'b10000, 1'b1);
        press("cur_D",  5'b01000, 1'b1);
        press("cur_L3", 5'b00100, 1'b1);
        press("cur_L4", 5'b00100, 1'b1);

        // P1 skill 2 (40) on P2 HP 60 -> 20, then P2's turn
        press("sel_R", 5'b00010, 1'b1);
        attack("atk_p1_s2");
        check("atk_p1_s2.p2_20", 32'(p2_cur_hp), 32'd20);
        // P2 skill 1 (10) on P1 -> 90
        attack("atk_p2_s1");
        // P1 skill 3 (50) on P2 HP 20 -> 0, P1 wins
        press("sel_R1", 5'b00010, 1'b1);
        press("sel_R2", 5'b00010, 1'b1);
        attack("atk_p1_s3");
        check("kill.p2_0", 32'(p2_cur_hp), 32'd0);
        check("kill.winner", 32'(winner), 32'd0);

        // DONE holds everything while the scene stays in fight
        for (int i = 0; i < 4; i++) begin
            press("done_hold", 5'($urandom), 1'b0);
            check_state("done_hold", ST_DONE);
            check_all("done_hold");
        end
        leave_scene("leave_done", c_scene_win);

        // Zero HP at entry ends the fight at the first CHECK
        set_stats(50, 200, 0, 7, 7, 0, 10, 9, 9, 9);
        enter_fight("zero_p2");
        attack("zero_p2_atk");
        leave_scene("leave_z1", c_scene_choose);
        set_stats(0, 10, 9, 9, 9, 50, 200, 5, 7, 7);
        enter_fight("zero_p1");
        attack("zero_p1_atk");
        leave_scene("leave_z2", c_scene_choose);

        // Leaving the scene mid-ANIMATE aborts without touching HP
        set_stats(90, 30, 25, 25, 25, 90, 20, 25, 25, 25);
        enter_fight("abort_entry");
        drive_keys(5'b00001);
        tick();
        drive_keys(5'b0);
        tick();
        tick();
        check_state("abort_mid", ST_ANIMATE);
        leave_scene("abort_leave", c_scene_choose);
        for (int i = 0; i < ANIM + 3; i++) tick();
        check_state("abort_stay", ST_IDLE);
        check_all("abort_stay");

        // Asynchronous reset mid-SELECT
        set_stats(77, 30, 11, 12, 13, 66, 40, 21, 22, 23);
        enter_fight("rst_sel_entry");
        press("rst_sel_R", 5'b00010, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        m_hp1 = 0; m_hp2 = 0; m_turn = 0; m_cursor = 0; m_done = 0; m_winner = 0;
        check_state("rst_async_sel", ST_IDLE);
        check_all("rst_async_sel");
        scene_state = c_scene_start;
        tick();
        reset = 1'b0;

        // Asynchronous reset mid-ANIMATE, then a clean attack with full latency
        enter_fight("rst_anim_entry");
        drive_keys(5'b00001);
        tick();
        drive_keys(5'b0);
        tick();
        #3;
        reset = 1'b1;
        #1;
        m_hp1 = 0; m_hp2 = 0; m_turn = 0; m_cursor = 0; m_done = 0; m_winner = 0;
        check_state("rst_async_anim", ST_IDLE);
        check_all("rst_async_anim");
        scene_state = c_scene_start;
        tick();
        reset = 1'b0;
        enter_fight("post_rst_entry");
        attack("post_rst_atk");
        leave_scene("post_rst_leave", c_scene_choose);

        // Randomized fights
        for (int f = 0; f < 6; f++) begin
            set_stats($urandom_range(0, 255), $urandom_range(0, 255),
                      $urandom_range(0, 120), $urandom_range(0, 120), $urandom_range(0, 120),
                      $urandom_range(0, 255), $urandom_range(0, 255),
                      $urandom_range(0, 120), $urandom_range(0, 120), $urandom_range(0, 120));
            enter_fight("rnd_entry");
            for (int a = 0; a < 40 && m_done == 0; a++) begin
                repeat ($urandom_range(0, 4)) press_rand("rnd_key");
                attack("rnd_atk");
            end
            leave_scene("rnd_leave", (f % 2 == 0) ? c_scene_win : c_scene_choose);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
